// File: rtl/scope_pkg.sv
// Shared constants, colours and capture state type for the scope trace renderer.
package scope_pkg;

  localparam int H_ACTIVE_DEF = 1280;
  localparam int V_ACTIVE_DEF = 1024;
  localparam int SAMPLE_W_DEF = 10;
  localparam int COORD_W      = 11;

  localparam logic [23:0] COL_TRACE = 24'h00FF00;
  localparam logic [23:0] COL_GRID  = 24'h404040;
  localparam logic [23:0] COL_BG    = 24'h000000;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } scope_state_e;

  // True when y lies on the vertical segment joining rows a and b (inclusive).
  function automatic logic span_hit(input logic [COORD_W-1:0] a,
                                    input logic [COORD_W-1:0] b,
                                    input logic [COORD_W-1:0] y);
    if (a <= b) return (y >= a) && (y <= b);
    return (y >= b) && (y <= a);
  endfunction

endpackage

// File: rtl/scope_trace_renderer_if.sv
// Sample, trigger, pixel-request and colour signals of the scope trace renderer.
interface scope_trace_renderer_if
  import scope_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
);
  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] trig_level;
  logic                trig_rising;
  logic                frame_start;
  logic [COORD_W-1:0]  pixel_x;
  logic [COORD_W-1:0]  pixel_y;
  logic                pixel_active;
  logic [7:0]          colour_R;
  logic [7:0]          colour_G;
  logic [7:0]          colour_B;
  logic                capture_done;
  logic                triggered_auto;

  modport master (
    output sample_in, sample_valid, trig_level, trig_rising, frame_start,
           pixel_x, pixel_y, pixel_active,
    input  colour_R, colour_G, colour_B, capture_done, triggered_auto
  );

  modport slave (
    input  sample_in, sample_valid, trig_level, trig_rising, frame_start,
           pixel_x, pixel_y, pixel_active,
    output colour_R, colour_G, colour_B, capture_done, triggered_auto
  );
endinterface

// File: rtl/scope_sample_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Address MSB selects the ping-pong buffer; each half is padded to a power of two.
module scope_sample_ram #(
  parameter int AW = 12,
  parameter int W  = 10
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [2**AW];

  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/scope_trace_renderer.sv
// Triggered capture into ping-pong line buffers plus a 2-cycle pixel colour pipeline.
// Optional graticule overlay: define SCOPE_GRID_OVERLAY_EN.
//
//   state   | meaning
//   ARMED   | watching kept samples for a trigger or timeout
//   CAPTURE | writing kept samples to the back buffer
//   DONE    | back buffer full, waiting for frame_start to swap
module scope_trace_renderer
  import scope_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int SAMPLE_W     = SAMPLE_W_DEF,
  parameter int DECIM        = 1,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic                  clock,
  input  logic                  reset,
  scope_trace_renderer_if.slave bus
);

  localparam int CW = $clog2(H_ACTIVE);
  localparam int AW = CW + 1;
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [CW-1:0]      LAST_COL = CW'(H_ACTIVE - 1);
  localparam logic [TW-1:0]      TO_LOAD  = TW'(AUTO_TIMEOUT - 1);
  localparam logic [7:0]         DEC_LOAD = 8'(DECIM - 1);
  localparam logic [COORD_W-1:0] ROW_MAX  = COORD_W'(V_ACTIVE - 1);

  scope_state_e state_q, state_d;

  logic [7:0]          dec_q;
  logic                kept;
  logic [SAMPLE_W-1:0] prev_q;
  logic                prev_vld_q;
  logic [TW-1:0]       to_q;
  logic [CW-1:0]       wr_addr_q;
  logic                disp_q, shown_q, auto_q;
  logic                rise_hit, fall_hit;
  logic                trig_real, trig_force, trig, wr_en, swap;
  logic [AW-1:0]       waddr;

  // Decimation down-counter: the sample seen at terminal count is kept.
  always_ff @(posedge clock) begin
    if (reset) dec_q <= 8'd0;
    else if (bus.sample_valid) dec_q <= (dec_q == 8'd0) ? DEC_LOAD : dec_q - 8'd1;
  end

  assign kept     = bus.sample_valid && (dec_q == 8'd0);
  assign rise_hit = (prev_q < bus.trig_level) && (bus.sample_in >= bus.trig_level);
  assign fall_hit = (prev_q > bus.trig_level) && (bus.sample_in <= bus.trig_level);

  always_ff @(posedge clock) begin
    if (reset) state_q <= ARMED;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARMED:   if (trig) state_d = CAPTURE;
      CAPTURE: if (kept && (wr_addr_q == LAST_COL)) state_d = DONE;
      DONE:    if (bus.frame_start) state_d = ARMED;
      default: state_d = ARMED;
    endcase
  end

  always_comb begin
    trig_real  = 1'b0;
    trig_force = 1'b0;
    wr_en      = 1'b0;
    swap       = 1'b0;
    case (state_q)
      ARMED: if (kept) begin
        trig_real  = prev_vld_q && (bus.trig_rising ? rise_hit : fall_hit);
        trig_force = !trig_real && (to_q == '0);
        wr_en      = trig_real || trig_force;
      end
      CAPTURE: wr_en = kept;
      DONE:    swap  = bus.frame_start;
      default: ;
    endcase
    trig = trig_real || trig_force;
  end

  // Re-arm on swap forgets the previous sample so no stale edge can trigger.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      to_q       <= TO_LOAD;
      wr_addr_q  <= '0;
      disp_q     <= 1'b0;
      shown_q    <= 1'b0;
      auto_q     <= 1'b0;
    end else begin
      if ((state_q == ARMED) && kept) begin
        prev_q     <= bus.sample_in;
        prev_vld_q <= 1'b1;
        if (!trig) to_q <= to_q - TW'(1);
      end
      if (trig) begin
        wr_addr_q <= CW'(1);
        auto_q    <= trig_force;
      end else if ((state_q == CAPTURE) && kept) begin
        wr_addr_q <= wr_addr_q + CW'(1);
      end
      if (swap) begin
        disp_q     <= ~disp_q;
        shown_q    <= 1'b1;
        prev_vld_q <= 1'b0;
        to_q       <= TO_LOAD;
      end
    end
  end

  assign waddr = {~disp_q, (state_q == ARMED) ? CW'(0) : wr_addr_q};

  // Two RAM copies give the current and left-neighbour columns in one read cycle.
  logic [CW-1:0]       x_col, x_prev;
  logic [SAMPLE_W-1:0] rd_cur, rd_prev;

  assign x_col  = bus.pixel_x[CW-1:0];
  assign x_prev = (x_col == '0) ? '0 : x_col - CW'(1);

  scope_sample_ram #(.AW(AW), .W(SAMPLE_W)) u_ram_cur (
    .clock   (clock),
    .we_i    (wr_en),
    .waddr_i (waddr),
    .wdata_i (bus.sample_in),
    .raddr_i ({disp_q, x_col}),
    .rdata_o (rd_cur)
  );

  scope_sample_ram #(.AW(AW), .W(SAMPLE_W)) u_ram_prev (
    .clock   (clock),
    .we_i    (wr_en),
    .waddr_i (waddr),
    .wdata_i (bus.sample_in),
    .raddr_i ({disp_q, x_prev}),
    .rdata_o (rd_prev)
  );

  logic [COORD_W-1:0] y1_q;
  logic               act1_q, inx1_q, show1_q, grid_hit;
  logic [COORD_W-1:0] cur_row, prev_row;
  logic               lit;
  logic [23:0]        colour_d, colour_q;

  // Until the first completed capture is displayed the buffers hold no trace.
  always_ff @(posedge clock) begin
    if (reset) begin
      y1_q    <= '0;
      act1_q  <= 1'b0;
      inx1_q  <= 1'b0;
      show1_q <= 1'b0;
    end else begin
      y1_q    <= bus.pixel_y;
      act1_q  <= bus.pixel_active;
      inx1_q  <= bus.pixel_x < COORD_W'(H_ACTIVE);
      show1_q <= shown_q;
    end
  end

`ifdef SCOPE_GRID_OVERLAY_EN
  logic grid1_q;

  always_ff @(posedge clock) begin
    if (reset) grid1_q <= 1'b0;
    else grid1_q <= (bus.pixel_x < COORD_W'(H_ACTIVE)) &&
                    ((bus.pixel_x[6:0] == 7'd0) || (bus.pixel_y[6:0] == 7'd0) ||
                     (bus.pixel_y == COORD_W'(V_ACTIVE / 2)));
  end

  assign grid_hit = grid1_q;
`else
  assign grid_hit = 1'b0;
`endif

  assign cur_row  = ROW_MAX - COORD_W'(rd_cur);
  assign prev_row = ROW_MAX - COORD_W'(rd_prev);
  assign lit      = show1_q && inx1_q && span_hit(prev_row, cur_row, y1_q);

  always_comb begin
    colour_d = COL_BG;
    if (!act1_q)       colour_d = COL_BG;
    else if (lit)      colour_d = COL_TRACE;
    else if (grid_hit) colour_d = COL_GRID;
  end

  always_ff @(posedge clock) begin
    if (reset) colour_q <= COL_BG;
    else       colour_q <= colour_d;
  end

  assign bus.colour_R       = colour_q[23:16];
  assign bus.colour_G       = colour_q[15:8];
  assign bus.colour_B       = colour_q[7:0];
  assign bus.capture_done   = (state_q == DONE);
  assign bus.triggered_auto = auto_q;

endmodule

// File: tb/tb_scope_trace_renderer.sv
// Scoreboard bench for scope_trace_renderer: directed captures, swaps and pixel probes.
module tb_scope_trace_renderer;
  import scope_pkg::*;

`ifdef SCOPE_GRID_OVERLAY_EN
  localparam bit GRID_EN = 1'b1;
`else
  localparam bit GRID_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  scope_trace_renderer_if bus ();

  scope_trace_renderer #(.DECIM(1), .AUTO_TIMEOUT(100)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [23:0] exp_q[$];
  string       tag_q[$];
  logic        req_flag = 1'b0;
  logic        d1 = 1'b0, d2 = 1'b0;
  logic [23:0] mon_got, mon_exp;
  string       mon_tag;
  int          cnt;

  always @(posedge clock) begin
    d1 <= req_flag;
    d2 <= d1;
  end

  always @(negedge clock) begin
    if (d2) begin
      mon_got = {bus.colour_R, bus.colour_G, bus.colour_B};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty actual=%06h", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_bad++;
          $display("FAIL %s actual=%06h required=%06h", mon_tag, mon_got, mon_exp);
        end
      end
    end
  end

  function automatic logic [23:0] bg(input int x, input int y);
    if (GRID_EN && x < 1280 && ((x % 128) == 0 || (y % 128) == 0 || y == 512)) return COL_GRID;
    return COL_BG;
  endfunction

  function automatic logic [9:0] gen(input int mode, input int idx);
    case (mode)
      0:       return 10'((500 + idx) % 1024);
      1:       return 10'd300;
      default: return (idx == 0) ? 10'd200 : (idx <= 10) ? 10'd100 : 10'd900;
    endcase
  endfunction

  task automatic check(input string t, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", t, got, exp);
    end
  endtask

  task automatic req(input int x, input int y, input bit act, input logic [23:0] e, input string t);
    @(posedge clock); #1;
    bus.pixel_x      = 11'(x);
    bus.pixel_y      = 11'(y);
    bus.pixel_active = act;
    req_flag         = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic req_end;
    @(posedge clock); #1;
    req_flag         = 1'b0;
    bus.pixel_active = 1'b0;
    repeat (3) @(posedge clock);
    #1;
  endtask

  // Feeds generated samples until capture_done rises; fs_at asserts frame_start mid-stream.
  task automatic capture(input int mode, input int fs_at, output int n);
    n = 0;
    while (bus.capture_done !== 1'b1 && n < 4000) begin
      bus.sample_in    = gen(mode, n);
      bus.sample_valid = 1'b1;
      bus.frame_start  = (n == fs_at);
      n++;
      @(posedge clock); #1;
    end
    bus.sample_valid = 1'b0;
    bus.frame_start  = 1'b0;
    check("capture_done_set", bus.capture_done, 1);
  endtask

  task automatic swap;
    bus.frame_start = 1'b1;
    @(posedge clock); #1;
    bus.frame_start = 1'b0;
    check("capture_done_drop", bus.capture_done, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.trig_level   = '0;
    bus.trig_rising  = 1'b1;
    bus.frame_start  = 1'b0;
    bus.pixel_x      = '0;
    bus.pixel_y      = '0;
    bus.pixel_active = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    check("reset_colour", {bus.colour_R, bus.colour_G, bus.colour_B}, 0);
    check("reset_capture_done", bus.capture_done, 0);
    check("reset_triggered_auto", bus.triggered_auto, 0);
    for (int i = 0; i < 8; i++) begin
      int rx, ry;
      rx = $urandom_range(0, 1279);
      ry = $urandom_range(0, 1022);
      req(rx, ry, 1'b1, bg(rx, ry), "reset_pixel");
    end
    req_end();
    check("idle_capture_done", bus.capture_done, 0);

    // Ramp from 500, rising through 512: trigger sample 512 lands in column 0.
    bus.trig_level  = 10'd512;
    bus.trig_rising = 1'b1;
    capture(0, -1, cnt);
    check("ramp_sample_count", cnt, 1292);
    check("ramp_auto", bus.triggered_auto, 0);
    bus.sample_in    = 10'd0;
    bus.sample_valid = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    bus.sample_valid = 1'b0;
    req(0, 511, 1'b1, bg(0, 511), "ramp_before_swap");
    req_end();
    swap();
    req(0, 511, 1'b1, COL_TRACE, "ramp_0_511");
    req(1, 510, 1'b1, COL_TRACE, "ramp_1_510");
    req(1, 511, 1'b1, COL_TRACE, "ramp_1_511");
    req(0, 0, 1'b1, bg(0, 0), "ramp_0_0");
    req(0, 512, 1'b1, bg(0, 512), "ramp_0_512");
    req(1279, 256, 1'b1, COL_TRACE, "ramp_1279_256");
    req(1279, 257, 1'b1, COL_TRACE, "ramp_1279_257");
    req(1279, 255, 1'b1, bg(1279, 255), "ramp_1279_255");
    req(1280, 256, 1'b1, COL_BG, "ramp_x_out_of_range");
    req(0, 511, 1'b0, COL_BG, "ramp_inactive");
    req(512, 0, 1'b1, COL_TRACE, "ramp_wrap_fill");
    req_end();

    // Constant 300, never crosses 1000: forced trigger on the 100th kept sample.
    bus.trig_level  = 10'd1000;
    bus.trig_rising = 1'b1;
    capture(1, 500, cnt);
    check("auto_sample_count", cnt, 1379);
    check("auto_flag", bus.triggered_auto, 1);
    req(0, 511, 1'b1, COL_TRACE, "auto_old_frame_kept");
    req(0, 723, 1'b1, bg(0, 723), "auto_old_frame_no_new");
    req_end();
    swap();
    req(0, 723, 1'b1, COL_TRACE, "auto_0_723");
    req(640, 723, 1'b1, COL_TRACE, "auto_640_723");
    req(1279, 723, 1'b1, COL_TRACE, "auto_1279_723");
    req(5, 722, 1'b1, bg(5, 722), "auto_5_722");
    req(5, 724, 1'b1, bg(5, 724), "auto_5_724");
    req(128, 5, 1'b1, bg(128, 5), "grid_128_5");
    req(5, 512, 1'b1, bg(5, 512), "grid_centre_row");
    req_end();

    // Falling trigger at 150, then step 100 -> 900 between columns 9 and 10.
    bus.trig_level  = 10'd150;
    bus.trig_rising = 1'b0;
    capture(2, -1, cnt);
    check("step_sample_count", cnt, 1281);
    check("step_auto_cleared", bus.triggered_auto, 0);
    swap();
    req(10, 123, 1'b1, COL_TRACE, "step_10_123");
    req(10, 500, 1'b1, COL_TRACE, "step_10_500");
    req(10, 923, 1'b1, COL_TRACE, "step_10_923");
    req(10, 122, 1'b1, bg(10, 122), "step_10_122");
    req(10, 924, 1'b1, bg(10, 924), "step_10_924");
    req(9, 923, 1'b1, COL_TRACE, "step_9_923");
    req(9, 922, 1'b1, bg(9, 922), "step_9_922");
    req(11, 123, 1'b1, COL_TRACE, "step_11_123");
    req(11, 124, 1'b1, bg(11, 124), "step_11_124");
    req_end();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
